// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding and
// the per-digit roll-over limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Highest legal value of a units digit and of a tens digit.
    localparam int unsigned ONES_LIMIT = 9;
    localparam int unsigned TENS_LIMIT = 5;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// Mod-(LIMIT+1) BCD digit counter. carry is combinational so a chain of
// digits ripples in the same cycle as the increment that causes it.
module bcd_digit #(
    parameter int unsigned LIMIT = 9
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    // Using >= rather than == means an out-of-range value can never survive
    // past its next increment.
    assign carry = inc && (value >= 4'(LIMIT));

    // Digit register: clear wins over increment, increment rolls to 0 at LIMIT.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!i_reset_n) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (inc) begin
            value <= carry ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by an in-domain square wave. A three-state
// FSM (IDLE/RUN/PAUSE) gates counting; four bcd_digit instances form the
// carry chain and a registered pulse flags the 59:59 -> 00:00 roll-over.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter bit COUNT_BOTH_EDGES = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick_in,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_clear,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_min_tens,
    output logic       o_running,
    output logic       o_wrap
);

    state_t state;
    state_t state_nxt;
    logic   tick_q;
    logic   primed;
    logic   edge_seen;
    logic   count_ev;
    logic   advance;
    logic   so_carry;
    logic   st_carry;
    logic   mo_carry;
    logic   mt_carry;

    // Previous tick sample plus a one-shot flag that masks the first cycle
    // after reset, when tick_q does not yet reflect the real input.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tick_q <= 1'b0;
            primed <= 1'b0;
        end else begin
            tick_q <= i_tick_in;
            primed <= 1'b1;
        end
    end

    assign edge_seen = COUNT_BOTH_EDGES ? (i_tick_in != tick_q) : (i_tick_in & ~tick_q);
    assign count_ev  = primed & edge_seen;
    // Clear in the same cycle as an event suppresses the increment entirely.
    assign advance   = (state == RUN) & count_ev & ~i_clear;

    bcd_digit #(.LIMIT(ONES_LIMIT)) u_sec_ones (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .inc(advance), .clr(i_clear),
        .value(o_sec_ones), .carry(so_carry)
    );
    bcd_digit #(.LIMIT(TENS_LIMIT)) u_sec_tens (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .inc(so_carry), .clr(i_clear),
        .value(o_sec_tens), .carry(st_carry)
    );
    bcd_digit #(.LIMIT(ONES_LIMIT)) u_min_ones (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .inc(st_carry), .clr(i_clear),
        .value(o_min_ones), .carry(mo_carry)
    );
    bcd_digit #(.LIMIT(TENS_LIMIT)) u_min_tens (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .inc(mo_carry), .clr(i_clear),
        .value(o_min_tens), .carry(mt_carry)
    );

    // Next-state decode with priority clear > stop > start.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (!i_stop && i_start) state_nxt = RUN;
                RUN:     if (i_stop)             state_nxt = PAUSE;
                PAUSE:   if (!i_stop && i_start) state_nxt = RUN;
                default:                         state_nxt = IDLE;
            endcase
        end
    end

    // State register with registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            o_running <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_running <= (state_nxt == RUN);
            o_wrap    <= mt_carry;
        end
    end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter COUNT_BOTH_EDGES, default 1, meaning 1 = every toggle of i_tick_in is one count, 0 = rising edges only.
REQ-002 i_clk  input  1  single clock; every flop in the block is clocked on its rising edge.
REQ-003 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_tick_in  input  1  square wave from the upstream timer (its freqOut), same clock domain, no synchronizer.
REQ-005 i_start  input  1  level, sampled each cycle; starts or resumes counting.
REQ-006 i_stop  input  1  level, sampled each cycle; pauses counting.
REQ-007 i_clear  input  1  level, sampled each cycle; zeroes the digits and returns the FSM to IDLE.
REQ-008 o_sec_ones  output  4  BCD seconds units, 0-9.
REQ-009 o_sec_tens  output  4  BCD seconds tens, 0-5.
REQ-010 o_min_ones  output  4  BCD minutes units, 0-9.
REQ-011 o_min_tens  output  4  BCD minutes tens, 0-5.
REQ-012 o_running  output  1  high while the FSM is in RUN.
REQ-013 o_wrap  output  1  one-cycle pulse when the count rolls over from 59:59 to 00:00.

Function
REQ-014 Edge detect: tick_q registers i_tick_in every cycle; a count event is asserted when (i_tick_in != tick_q) if COUNT_BOTH_EDGES=1, or when (i_tick_in & ~tick_q) if COUNT_BOTH_EDGES=0.
REQ-015 A primed flag is cleared by reset and set on the first clock after reset; count events are suppressed while primed=0, so no false edge is seen after reset.
REQ-016 FSM states and transitions: IDLE (reset state), RUN, PAUSE; IDLE->RUN on start, RUN->PAUSE on stop, PAUSE->RUN on start, any state->IDLE on clear; no other transitions.
REQ-017 Command priority: clear > stop > start; start while in RUN and stop while in IDLE or PAUSE have no effect.
REQ-018 The digits advance by 1 second at the clock edge where the FSM is in RUN and a count event is asserted; outputs change 1 cycle after i_tick_in changes.
REQ-019 A stop asserted in the same cycle as a count event, while in RUN, still lets that count be applied; the state change takes effect at the next edge.
REQ-020 A clear asserted in the same cycle as a count event wins: all digits are 0 and o_wrap stays 0.
REQ-021 Carry chain: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 wraps the whole count.
REQ-022 o_wrap is high for exactly the one cycle after the 59:59->00:00 increment.
REQ-023 PAUSE holds all digits; IDLE holds all digits at 0; start from IDLE begins counting from 00:00.
REQ-024 Digit registers never hold non-BCD values or values beyond the limits in REQ-008 to REQ-011.

Reset
REQ-025 While i_reset_n=0, independent of the clock: all digits 0, tick_q=0, primed=0, FSM=IDLE, o_running=0, o_wrap=0.
REQ-026 Reset asserted mid-count aborts immediately with no partial carry; after release the block waits in IDLE for start.

Structure
REQ-027 Package stopwatch_pkg holds the state enum (IDLE, RUN, PAUSE) and the digit limit constants (9, 5).
REQ-028 Sub-module bcd_digit is a mod-N digit counter with inputs inc and clr, outputs value and carry, and parameter LIMIT; it is instantiated four times.

Verification
REQ-029 Scenario: reset, start, 10 toggles of i_tick_in with COUNT_BOTH_EDGES=1 -> display reads 00:10, o_running=1.
REQ-030 Scenario: same 10 toggles with COUNT_BOTH_EDGES=0 -> display reads 00:05.
REQ-031 Scenario: run to 00:59, then 1 more event -> display reads 01:00; run to 59:59, then 1 event -> display reads 00:00 and o_wrap is high for exactly 1 cycle.
REQ-032 Scenario: at 00:03, stop and clear asserted together with an edge -> display reads 00:00, state IDLE, o_running=0.
REQ-033 Scenario: at 00:07, stop; 4 toggles; start; 2 toggles -> display reads 00:09.
REQ-034 Scenario: i_tick_in=1 at reset release -> no count; i_reset_n low for 1 cycle mid-count at 12:34 -> display reads 00:00 asynchronously.
